grf_wb_arbiter: RTL and testbench

- Shares the single GRF write port between two writers:
  - the W-stage pipeline writeback, which can never be stalled;
  - an auxiliary long-latency writer (MDU/CP0-style result return), which uses a valid/ready handshake.
- Aux writes are buffered in a small in-order FIFO and drained into idle write-port cycles.
- The block keeps a pending-write scoreboard, so the hazard logic can stall a D-stage read of a register whose aux write has not landed.
- Sits between the W stage, the aux unit and the GRF write port.

---
 rtl/grf_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_grf_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the unstallable W-stage writeback
// and a buffered aux writer, tracking pending aux writes for D-stage hazard stalls.
module grf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic [31:0] pipe_pc,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    input  logic [31:0] aux_pc,
    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_data,
    output logic [31:0] grf_pc,
    input  logic [4:0]  rd1_addr,
    input  logic [4:0]  rd2_addr,
    output logic [31:0] pend_mask,
    output logic        stall_d,
    output logic        stall_req
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0]        ent_killed;
    logic [DEPTH-1:0][4:0]   ent_addr;
    logic [DEPTH-1:0][31:0]  ent_data;
    logic [DEPTH-1:0][31:0]  ent_pc;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [CW-1:0]           count;
    logic [SW-1:0]           starve_cnt;

    logic [DEPTH-1:0] live;
    logic             pipe_grant;
    logic             head_live;
    logic             pop;
    logic             push;
    logic [31:0]      pend_raw;

    assign live       = ent_valid & ~ent_killed;
    assign pipe_grant = pipe_we && (pipe_addr != 5'd0);
    assign head_live  = live[rd_ptr];
    // A killed head leaves regardless of who owns the port; a live one only when the pipe is idle.
    assign pop        = ent_valid[rd_ptr] && (ent_killed[rd_ptr] || !pipe_grant);
    assign aux_ready  = !reset && (count < CW'(DEPTH));
    assign push       = aux_valid && aux_ready && (aux_addr != 5'd0);

    always_comb begin
        grf_we   = 1'b0;
        grf_addr = '0;
        grf_data = '0;
        grf_pc   = '0;
        if (!reset) begin
            if (pipe_grant) begin
                grf_we   = 1'b1;
                grf_addr = pipe_addr;
                grf_data = pipe_data;
                grf_pc   = pipe_pc;
            end else if (head_live) begin
                grf_we   = 1'b1;
                grf_addr = ent_addr[rd_ptr];
                grf_data = ent_data[rd_ptr];
                grf_pc   = ent_pc[rd_ptr];
            end
        end
    end

    always_comb begin
        pend_raw = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live[i]) pend_raw[ent_addr[i]] = 1'b1;
    end

    assign pend_mask = reset ? '0 : pend_raw;
    assign stall_d   = ((rd1_addr != 5'd0) && pend_mask[rd1_addr]) ||
                       ((rd2_addr != 5'd0) && pend_mask[rd2_addr]);
    assign stall_req = !reset && (starve_cnt == SW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid  <= '0;
            ent_killed <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            // Pipe value is younger than anything already buffered for the same register.
            for (int i = 0; i < DEPTH; i++)
                if (pipe_grant && live[i] && (ent_addr[i] == pipe_addr))
                    ent_killed[i] <= 1'b1;
            if (pop) begin
                ent_valid[rd_ptr]  <= 1'b0;
                ent_killed[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + PW'(1);
            end
            if (push) begin
                ent_valid[wr_ptr]  <= 1'b1;
                ent_killed[wr_ptr] <= 1'b0;
                ent_addr[wr_ptr]   <= aux_addr;
                ent_data[wr_ptr]   <= aux_data;
                ent_pc[wr_ptr]     <= aux_pc;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (pop || (count == '0))
                starve_cnt <= '0;
            else if (head_live && pipe_grant && (starve_cnt != SW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed plus randomized bench for grf_wb_arbiter against a queue-based
// model of the aux buffer, the port grant and the register file contents.
module tb_grf_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic        clk, reset;
    logic        pipe_we, aux_valid, aux_ready, grf_we, stall_d, stall_req;
    logic [4:0]  pipe_addr, aux_addr, grf_addr, rd1_addr, rd2_addr;
    logic [31:0] pipe_data, pipe_pc, aux_data, aux_pc, grf_data, grf_pc, pend_mask;

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr),
        .aux_data(aux_data), .aux_pc(aux_pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data), .grf_pc(grf_pc),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .pend_mask(pend_mask), .stall_d(stall_d), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        bit          killed;
    } ent_t;

    ent_t        q[$];
    int          starve;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf   [32];
    int          n_cmp, n_err;
    bit          acc;
    logic        obs_we, obs_ready, obs_req, obs_stall_d;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data, obs_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv_pipe(input bit we, input logic [4:0] a, input logic [31:0] d);
        pipe_we = we; pipe_addr = a; pipe_data = d;
        pipe_pc = 32'h0040_0000 + 32'(a) * 4;
    endtask

    task automatic drv_aux(input bit v, input logic [4:0] a, input logic [31:0] d);
        aux_valid = v; aux_addr = a; aux_data = d;
        aux_pc = 32'h0080_0000 + 32'(a) * 4;
    endtask

    // One clock: compare DUT against the model at the negedge, then advance the model.
    task automatic cyc();
        bit pg, live_head, was_empty, pop, e_ready, e_we, e_stall_d;
        logic [4:0]  e_addr;
        logic [31:0] e_data, e_pc, e_pend;
        @(negedge clk);
        obs_we = grf_we; obs_addr = grf_addr; obs_data = grf_data; obs_ready = aux_ready;
        obs_req = stall_req; obs_stall_d = stall_d; obs_pend = pend_mask;
        pg        = pipe_we && pipe_addr != 0;
        e_ready   = q.size() < DEPTH;
        live_head = q.size() > 0 && !q[0].killed;
        e_we = 0; e_addr = 0; e_data = 0; e_pc = 0;
        if (pg) begin
            e_we = 1; e_addr = pipe_addr; e_data = pipe_data; e_pc = pipe_pc;
        end else if (live_head) begin
            e_we = 1; e_addr = q[0].addr; e_data = q[0].data; e_pc = q[0].pc;
        end
        e_pend = 0;
        foreach (q[i]) if (!q[i].killed) e_pend[q[i].addr] = 1'b1;
        e_stall_d = (rd1_addr != 0 && e_pend[rd1_addr]) || (rd2_addr != 0 && e_pend[rd2_addr]);
        chk("grf_we", 32'(grf_we), 32'(e_we));
        chk("grf_addr", 32'(grf_addr), 32'(e_addr));
        chk("grf_data", grf_data, e_data);
        chk("grf_pc", grf_pc, e_pc);
        chk("aux_ready", 32'(aux_ready), 32'(e_ready));
        chk("pend_mask", pend_mask, e_pend);
        chk("stall_d", 32'(stall_d), 32'(e_stall_d));
        chk("stall_req", 32'(stall_req), 32'(starve == LIMIT));

        acc       = aux_valid && e_ready;
        was_empty = q.size() == 0;
        pop       = !was_empty && (q[0].killed || !pg);
        if (e_we) model_rf[e_addr] = e_data;
        if (grf_we) dut_rf[grf_addr] = grf_data;
        if (pop || was_empty) starve = 0;
        else if (starve < LIMIT) starve++;
        if (pg) foreach (q[i]) if (q[i].addr == pipe_addr) q[i].killed = 1;
        if (pop) void'(q.pop_front());
        if (acc && aux_addr != 0) q.push_back('{aux_addr, aux_data, aux_pc, 1'b0});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_grf_we", 32'(grf_we), 32'd0);
        chk("rst_aux_ready", 32'(aux_ready), 32'd0);
        chk("rst_stall_req", 32'(stall_req), 32'd0);
        chk("rst_pend_mask", pend_mask, 32'd0);
        chk("rst_stall_d", 32'(stall_d), 32'd0);
        q.delete();
        starve = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; starve = 0; acc = 0;
        for (int i = 0; i < 32; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end
        reset = 1'b1; rd1_addr = 0; rd2_addr = 0;
        drv_pipe(0, 0, 0); drv_aux(0, 0, 0);
        #1;
        do_reset();

        // Idle pipe: aux $5 lands one cycle after acceptance.
        drv_aux(1, 5, 32'h1111_1111); cyc();
        drv_aux(0, 0, 0); cyc();
        chk("t1_we", 32'(obs_we), 32'd1);
        chk("t1_addr", 32'(obs_addr), 32'd5);
        chk("t1_data", obs_data, 32'h1111_1111);
        chk("t1_pend", obs_pend, 32'h0000_0020);
        cyc();
        chk("t1_pend_after", obs_pend, 32'd0);

        // Busy pipe starves aux $7 until stall_req asserts.
        drv_pipe(1, 3, 32'h3333); drv_aux(1, 7, 32'h7777); cyc();
        drv_aux(0, 0, 0);
        for (int i = 0; i < 8; i++) cyc();
        chk("t2_req_early", 32'(obs_req), 32'd0);
        cyc();
        chk("t2_req_high", 32'(obs_req), 32'd1);
        drv_pipe(0, 0, 0); cyc();
        chk("t2_drain_addr", 32'(obs_addr), 32'd7);
        chk("t2_req_still", 32'(obs_req), 32'd1);
        cyc();
        chk("t2_req_low", 32'(obs_req), 32'd0);

        // Younger pipe write to $9 kills the buffered entry.
        drv_pipe(1, 3, 32'h3); drv_aux(1, 9, 32'h9999); cyc();
        drv_aux(0, 0, 0); drv_pipe(1, 9, 32'hAAAA); cyc();
        drv_pipe(0, 0, 0); cyc();
        chk("t3_no_write", 32'(obs_we), 32'd0);
        chk("t3_pend9", 32'(obs_pend[9]), 32'd0);
        chk("t3_rf9", dut_rf[9], 32'hAAAA);

        // Same-cycle pipe and aux to $4: aux is younger and wins.
        drv_pipe(1, 4, 32'h1); drv_aux(1, 4, 32'h2); cyc();
        drv_pipe(0, 0, 0); drv_aux(0, 0, 0); cyc();
        chk("t4_data", obs_data, 32'h2);
        chk("t4_rf4", dut_rf[4], 32'h2);

        // Full FIFO back-pressure, then an aux $0 request.
        drv_pipe(1, 3, 32'h5); drv_aux(1, 10, 32'h10); cyc();
        drv_aux(1, 11, 32'h11); cyc();
        drv_aux(1, 12, 32'h12); cyc();
        chk("t5_full_ready", 32'(obs_ready), 32'd0);
        cyc();
        drv_pipe(0, 0, 0); cyc();
        chk("t5_pop_ready", 32'(obs_ready), 32'd0);
        chk("t5_pop_addr", 32'(obs_addr), 32'd10);
        cyc();
        chk("t5_accept", 32'(obs_ready), 32'd1);
        drv_aux(0, 0, 0); cyc(); cyc();
        chk("t5_rf12", dut_rf[12], 32'h12);
        drv_aux(1, 0, 32'hDEAD); cyc();
        chk("t5_zero_ack", 32'(obs_ready), 32'd1);
        drv_aux(0, 0, 0); cyc();
        chk("t5_zero_nowrite", 32'(obs_we), 32'd0);

        // Scoreboard stall, then reset while entries are buffered.
        drv_pipe(1, 3, 32'h6); drv_aux(1, 6, 32'h66); cyc();
        drv_aux(1, 8, 32'h88); rd1_addr = 6; rd2_addr = 0; cyc();
        chk("t6_stall", 32'(obs_stall_d), 32'd1);
        drv_aux(0, 0, 0); rd1_addr = 1; cyc();
        chk("t6_rd2_zero", 32'(obs_stall_d), 32'd0);
        drv_pipe(0, 0, 0); rd1_addr = 0;
        do_reset();
        cyc();
        chk("t6_post_we", 32'(obs_we), 32'd0);
        chk("t6_post_pend", obs_pend, 32'd0);

        // Randomized traffic with phases of heavy and light pipe load.
        for (int n = 0; n < 600; n++) begin
            int busy;
            busy = ((n / 60) % 2 == 0) ? 90 : 40;
            if ($urandom_range(0, 99) < busy)
                drv_pipe(1, 5'($urandom_range(0, 7)), $urandom);
            else
                drv_pipe(0, 5'($urandom_range(0, 7)), $urandom);
            if (!aux_valid || acc) begin
                if ($urandom_range(0, 2) != 0) drv_aux(1, 5'($urandom_range(0, 7)), $urandom);
                else drv_aux(0, 0, 0);
            end
            rd1_addr = 5'($urandom_range(0, 7));
            rd2_addr = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0) do_reset();
            else cyc();
        end

        for (int r = 0; r < 32; r++) chk($sformatf("rf%0d", r), dut_rf[r], model_rf[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
